// File: rtl/md5_guess_generator.sv
// Brute-force candidate enumerator feeding the MD5 pipeline: walks every string over
// [CHAR_MIN, CHAR_MAX] for lengths min_len..max_len, one candidate per consumed cycle.
module md5_guess_generator #(
  parameter logic [7:0] CHAR_MIN = 8'h61,
  parameter logic [7:0] CHAR_MAX = 8'h7a
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   min_len,
  input  logic [3:0]   max_len,
  input  logic         en,
  output logic [127:0] guess,
  output logic [3:0]   guesslen,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [63:0]  count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic [3:0]   max_len_q;
  logic         legal;
  logic         accept;
  logic         consume;
  logic         carry;
  logic         last;
  logic [127:0] guess_next;
  logic [127:0] guess_first;
  logic [3:0]   len_next;

  always_comb begin
    legal   = (min_len != 4'd0) && (min_len <= max_len);
    accept  = start && (state != RUN);
    consume = (state == RUN) && en;
    valid   = (state == RUN);
    busy    = (state == RUN);
    done    = (state == DONE);
  end

  // Odometer advance: position 0 is least significant; carry stops at guesslen-1.
  always_comb begin
    guess_next = guess;
    len_next   = guesslen;
    carry      = 1'b1;
    last       = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if ((4'(i) < guesslen) && carry) begin
        if (guess[127-8*i -: 8] == CHAR_MAX) begin
          guess_next[127-8*i -: 8] = CHAR_MIN;
        end else begin
          guess_next[127-8*i -: 8] = guess[127-8*i -: 8] + 8'd1;
          carry = 1'b0;
        end
      end
    end
    if (carry) begin
      if (guesslen < max_len_q) begin
        // Lower positions already wrapped to CHAR_MIN; only the new top byte needs seeding.
        len_next = guesslen + 4'd1;
        for (int unsigned i = 0; i < 16; i++) begin
          if (4'(i) == guesslen) guess_next[127-8*i -: 8] = CHAR_MIN;
        end
      end else begin
        last = 1'b1;
      end
    end
  end

  always_comb begin
    guess_first = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (4'(i) < min_len) guess_first[127-8*i -: 8] = CHAR_MIN;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = legal ? RUN : DONE;
      RUN:        if (consume && last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      guess     <= '0;
      guesslen  <= '0;
      err       <= 1'b0;
      count     <= '0;
      max_len_q <= '0;
    end else if (accept) begin
      count <= '0;
      err   <= !legal;
      if (legal) begin
        guess     <= guess_first;
        guesslen  <= min_len;
        max_len_q <= max_len;
      end
    end else if (consume) begin
      if (count != '1) count <= count + 64'd1;
      if (!last) begin
        guess    <= guess_next;
        guesslen <= len_next;
      end
    end
  end

endmodule

// File: tb/tb_md5_guess_generator.sv
// Bench for md5_guess_generator: two instances (chars a..c and default a..z) checked every
// cycle against a base-N counting model, plus directed hand-computed expectations.
module tb_md5_guess_generator;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i [2];
  logic [3:0]   minl    [2];
  logic [3:0]   maxl    [2];
  logic         en_i    [2];
  logic [127:0] guess_o [2];
  logic [3:0]   len_o   [2];
  logic         valid_o [2];
  logic         busy_o  [2];
  logic         done_o  [2];
  logic         err_o   [2];
  logic [63:0]  count_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  md5_guess_generator #(.CHAR_MIN(8'h61), .CHAR_MAX(8'h63)) dut_abc (
    .clk(clk), .reset(reset), .start(start_i[0]), .min_len(minl[0]), .max_len(maxl[0]),
    .en(en_i[0]), .guess(guess_o[0]), .guesslen(len_o[0]), .valid(valid_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .count(count_o[0])
  );

  md5_guess_generator dut_az (
    .clk(clk), .reset(reset), .start(start_i[1]), .min_len(minl[1]), .max_len(maxl[1]),
    .en(en_i[1]), .guess(guess_o[1]), .guesslen(len_o[1]), .valid(valid_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .count(count_o[1])
  );

  function automatic void chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: expected {len, guess} sequence per instance
  logic [131:0] q0[$];
  logic [131:0] q1[$];
  bit              run   [2];
  bit              edone [2];
  bit              eerr  [2];
  bit              hv    [2];
  longint unsigned ecnt  [2];
  logic [131:0]    last_g[2];

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [131:0] qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int d, input logic [131:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic qpop(input int d, output logic [131:0] v);
    if (d == 0) v = q0.pop_front();
    else        v = q1.pop_front();
  endtask

  task automatic qclear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  // Every string of length L is the L-digit base-N expansion of k, digit 0 first.
  task automatic gen(input int d, input int lo, input int hi, input int mn, input int mx);
    int n;
    n = hi - lo + 1;
    for (int L = mn; L <= mx; L++) begin
      int total;
      total = 1;
      for (int p = 0; p < L; p++) total *= n;
      for (int k = 0; k < total; k++) begin
        logic [127:0] g;
        int v;
        g = '0;
        v = k;
        for (int p = 0; p < L; p++) begin
          g[127-8*p -: 8] = 8'(lo + v % n);
          v = v / n;
        end
        qpush(d, {4'(L), g});
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          qclear(d);
          run[d] = 0; edone[d] = 0; eerr[d] = 0; ecnt[d] = 0;
          last_g[d] = '0; hv[d] = 1;
        end else if (start_i[d] && !run[d]) begin
          ecnt[d] = 0;
          hv[d] = 0;
          if (minl[d] != 4'd0 && minl[d] <= maxl[d]) begin
            qclear(d);
            gen(d, 8'h61, (d == 0) ? 8'h63 : 8'h7a, int'(minl[d]), int'(maxl[d]));
            run[d] = 1; edone[d] = 0; eerr[d] = 0;
          end else begin
            run[d] = 0; edone[d] = 1; eerr[d] = 1;
          end
        end else if (run[d] && en_i[d]) begin
          qpop(d, last_g[d]);
          ecnt[d]++;
          if (qsize(d) == 0) begin
            run[d] = 0; edone[d] = 1; hv[d] = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("valid%0d", d), valid_o[d], run[d]);
        chk($sformatf("busy%0d", d), busy_o[d], run[d]);
        chk($sformatf("done%0d", d), done_o[d], edone[d]);
        chk($sformatf("err%0d", d), err_o[d], eerr[d]);
        chk($sformatf("count%0d", d), count_o[d], ecnt[d]);
        if (run[d] && qsize(d) > 0)
          chk($sformatf("guess%0d", d), {len_o[d], guess_o[d]}, qfront(d));
        else if (hv[d])
          chk($sformatf("held%0d", d), {len_o[d], guess_o[d]}, last_g[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d, input logic [3:0] mn, input logic [3:0] mx);
    minl[d] = mn;
    maxl[d] = mx;
    start_i[d] = 1'b1;
    tick();
    start_i[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input string name);
    for (int k = 0; k < 200 && !done_o[d]; k++) tick();
    chk(name, done_o[d], 1'b1);
  endtask

  logic [127:0] held;

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 1'b0; minl[d] = 4'd0; maxl[d] = 4'd0; en_i[d] = 1'b1;
    end
    tick(); tick();
    chk("reset_guess", guess_o[0], 128'h0);
    chk("reset_len", len_o[0], 4'd0);
    chk("reset_flags", {valid_o[0], busy_o[0], done_o[0], err_o[0]}, 4'b0000);
    chk("reset_count", count_o[0], 64'd0);
    reset = 1'b0;
    tick();

    // a..z, length 1 only
    pulse_start(1, 4'd1, 4'd1);
    chk("az_first", {len_o[1], guess_o[1]}, {4'd1, 8'h61, 120'h0});
    chk("az_model_size", 132'(qsize(1)), 132'd26);
    wait_done(1, "az_done");
    chk("az_count", count_o[1], 64'd26);
    chk("az_last", {len_o[1], guess_o[1]}, {4'd1, 8'h7a, 120'h0});

    // a..c, lengths 1..2
    pulse_start(0, 4'd1, 4'd2);
    chk("abc_model_size", 132'(qsize(0)), 132'd12);
    tick(); tick(); tick(); tick();
    chk("abc_fifth", {len_o[0], guess_o[0]}, {4'd2, 16'h6261, 112'h0});
    wait_done(0, "abc_done");
    chk("abc_count", count_o[0], 64'd12);
    chk("abc_last", {len_o[0], guess_o[0]}, {4'd2, 16'h6363, 112'h0});

    // restart from DONE with a stall after the 4th guess
    pulse_start(0, 4'd1, 4'd2);
    chk("restart_count", count_o[0], 64'd0);
    chk("restart_err", err_o[0], 1'b0);
    tick(); tick(); tick();
    chk("stall_fourth", {len_o[0], guess_o[0]}, {4'd2, 16'h6161, 112'h0});
    en_i[0] = 1'b0;
    held = guess_o[0];
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_guess", guess_o[0], held);
      chk("stall_count", count_o[0], 64'd3);
      chk("stall_valid", valid_o[0], 1'b1);
    end
    en_i[0] = 1'b1;
    tick();
    chk("resume_fifth", {len_o[0], guess_o[0]}, {4'd2, 16'h6261, 112'h0});
    wait_done(0, "stall_done");
    chk("stall_total", count_o[0], 64'd12);

    // illegal configurations
    pulse_start(0, 4'd0, 4'd3);
    chk("ill0_flags", {valid_o[0], done_o[0], err_o[0]}, 3'b011);
    tick();
    pulse_start(0, 4'd5, 4'd3);
    chk("ill1_flags", {valid_o[0], done_o[0], err_o[0]}, 3'b011);
    tick();

    // reset mid-run
    pulse_start(0, 4'd1, 4'd2);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_flags", {valid_o[0], busy_o[0], done_o[0], err_o[0]}, 4'b0000);
    chk("rst_count", count_o[0], 64'd0);
    chk("rst_guess", guess_o[0], 128'h0);
    tick();
    pulse_start(0, 4'd1, 4'd2);
    chk("rst_restart", {len_o[0], guess_o[0]}, {4'd1, 8'h61, 120'h0});

    // start during RUN is ignored
    tick(); tick();
    pulse_start(0, 4'd3, 4'd3);
    chk("ignore_seq", {len_o[0], guess_o[0]}, {4'd2, 16'h6161, 112'h0});
    wait_done(0, "ignore_done");
    chk("ignore_count", count_o[0], 64'd12);

    // fresh run from DONE with new lengths
    pulse_start(0, 4'd2, 4'd2);
    chk("fresh_first", {len_o[0], guess_o[0]}, {4'd2, 16'h6161, 112'h0});
    chk("fresh_err", err_o[0], 1'b0);
    wait_done(0, "fresh_done");
    chk("fresh_count", count_o[0], 64'd9);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
